// File: rtl/rv32_pkg.sv
// Shared rv32 types: instruction word, default imem address, and the program-loader state set.
package rv32_pkg;

  localparam int unsigned RV32_IMEM_ADDR_W = 10;

  typedef logic [RV32_IMEM_ADDR_W-1:0] rv32_imem_addr_t;
  typedef logic [31:0]                 rv32_instr_t;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StData,
    StChk,
    StWaitWr,
    StDone,
    StErr
  } loader_state_e;

endpackage

// File: rtl/rv32_byte_packer.sv
// Little-endian 4-byte assembler. word_valid_o pulses combinationally on the 4th byte.
module rv32_byte_packer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o,
  output logic [1:0]  count_o
);

  logic [23:0] pack_q, pack_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    pack_d = pack_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      pack_d = '0;
      cnt_d  = '0;
    end else if (byte_en_i) begin
      unique case (cnt_q)
        2'd0: pack_d[7:0]   = byte_i;
        2'd1: pack_d[15:8]  = byte_i;
        2'd2: pack_d[23:16] = byte_i;
        2'd3: pack_d        = '0;
        default: pack_d     = '0;
      endcase
      cnt_d = cnt_q + 2'd1;
    end
  end

  // The completed word bypasses the register so the consumer sees it in the 4th-byte cycle.
  assign word_o       = {byte_i, pack_q};
  assign word_valid_o = byte_en_i && !flush_i && (cnt_q == 2'd3);
  assign count_o      = cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pack_q <= '0;
      cnt_q  <= '0;
    end else begin
      pack_q <= pack_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/rv32_prog_loader.sv
// Byte-stream program loader for rv32 instruction memory.
// Define RV32_LOADER_CHKSUM_EN to require a trailing XOR checksum word.
module rv32_prog_loader
  import rv32_pkg::*;
#(
  parameter int unsigned IMEM_ADDR_W = 10,
  parameter int unsigned MAX_WORDS   = 2 ** IMEM_ADDR_W
) (
  input  logic                   rv32_io_clk,
  input  logic                   rv32_io_rst,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   imem_w_en,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  output logic [31:0]            imem_data,
  output logic                   core_rst_n,
  output logic                   program_mode,
  output logic                   done,
  output logic                   error,
  output logic [IMEM_ADDR_W:0]   words_loaded
);

`ifdef RV32_LOADER_CHKSUM_EN
  localparam loader_state_e StLast = StChk;
`else
  localparam loader_state_e StLast = StDone;
`endif

  loader_state_e          state_q, state_d;
  logic [31:0]            n_q, n_d;
  logic [IMEM_ADDR_W:0]   words_q, words_d;
  logic [IMEM_ADDR_W-1:0] addr_q, addr_d;
  rv32_instr_t            data_q, data_d;
`ifdef RV32_LOADER_CHKSUM_EN
  rv32_instr_t            chk_q, chk_d;
`endif

  logic        flush;
  logic        pk_valid;
  rv32_instr_t pk_word;
  logic [1:0]  pk_count;

  rv32_byte_packer u_packer (
    .clk_i        (rv32_io_clk),
    .rst_i        (rv32_io_rst),
    .flush_i      (flush),
    .byte_en_i    (in_valid && in_ready),
    .byte_i       (in_data),
    .word_valid_o (pk_valid),
    .word_o       (pk_word),
    .count_o      (pk_count)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    words_d = words_q;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef RV32_LOADER_CHKSUM_EN
    chk_d   = chk_q;
`endif
    flush   = 1'b0;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d = StHdr;
          words_d = '0;
          flush   = 1'b1;
`ifdef RV32_LOADER_CHKSUM_EN
          chk_d   = '0;
`endif
        end
      end
      StHdr: begin
        if (pk_valid) begin
          n_d = pk_word;
          if (pk_word == 32'd0)                   state_d = StLast;
          else if (pk_word > 32'(MAX_WORDS))      state_d = StErr;
          else                                    state_d = StData;
        end
      end
      StData: begin
        if (pk_valid) begin
          data_d  = pk_word;
          addr_d  = words_q[IMEM_ADDR_W-1:0];
          state_d = StWaitWr;
`ifdef RV32_LOADER_CHKSUM_EN
          chk_d   = chk_q ^ pk_word;
`endif
        end
      end
      StWaitWr: begin
        words_d = words_q + (IMEM_ADDR_W+1)'(1);
        state_d = (32'(words_d) == n_q) ? StLast : StData;
      end
      StChk: begin
`ifdef RV32_LOADER_CHKSUM_EN
        if (pk_valid) state_d = (pk_word == chk_q) ? StDone : StErr;
`else
        state_d = StErr;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge rv32_io_clk) begin
    if (rv32_io_rst) begin
      state_q <= StIdle;
      n_q     <= '0;
      words_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef RV32_LOADER_CHKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      words_q <= words_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef RV32_LOADER_CHKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  // Packer count is informational only; sessions always end on a word boundary or flush.
  logic unused_count;
  assign unused_count = ^pk_count;

  assign in_ready     = (state_q == StHdr) || (state_q == StData) || (state_q == StChk);
  assign imem_w_en    = (state_q == StWaitWr);
  assign imem_addr    = addr_q;
  assign imem_data    = data_q;
  assign core_rst_n   = (state_q == StDone);
  assign program_mode = (state_q == StHdr) || (state_q == StData) || (state_q == StChk) ||
                        (state_q == StWaitWr);
  assign done         = (state_q == StDone);
  assign error        = (state_q == StErr);
  assign words_loaded = words_q;

endmodule

// File: tb/tb_rv32_prog_loader.sv
// Directed bench for rv32_prog_loader; honours RV32_LOADER_CHKSUM_EN when defined.
module tb_rv32_prog_loader;

  localparam int unsigned AW = 4;
  localparam int unsigned MW = 12;

  logic          clk = 1'b0;
  logic          rst, start, in_valid;
  logic [7:0]    in_data;
  logic          in_ready, imem_w_en, core_rst_n, program_mode, done, error;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic [AW:0]   words_loaded;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0]   wr_data_q[$];
  logic [AW-1:0] wr_addr_q[$];

  rv32_prog_loader #(.IMEM_ADDR_W(AW), .MAX_WORDS(MW)) dut (
    .rv32_io_clk  (clk),
    .rv32_io_rst  (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .imem_w_en    (imem_w_en),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .core_rst_n   (core_rst_n),
    .program_mode (program_mode),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_w_en) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_data);
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t = 0;
    if (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      vectors++; miscompares++;
      $display("FAIL byte_timeout: in_ready=%b after %0d cycles, required 1", in_ready, t);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic send_chk(input logic [31:0] w, input bit gap);
`ifdef RV32_LOADER_CHKSUM_EN
    send_word(w, gap);
`else
    if (gap && w == 32'hFFFF_FFFF) @(negedge clk);
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end();
    int t = 0;
    while (!(done || error) && t < 50) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (t >= 50) begin
      miscompares++;
      $display("FAIL end_timeout: done=%b error=%b, required one of them high", done, error);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    vectors++;
    if ({in_ready, imem_w_en, core_rst_n, program_mode, done, error} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: rdy,wen,crst_n,prog,done,err=%b required 000000",
               {in_ready, imem_w_en, core_rst_n, program_mode, done, error});
    end
    vectors++;
    if (imem_addr !== '0 || imem_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_imem: addr=%h data=%h required 0/0", imem_addr, imem_data);
    end
    vectors++;
    if (words_loaded !== '0) begin
      miscompares++;
      $display("FAIL reset_words: words_loaded=%0d required 0", words_loaded);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One word; a stray start inside DATA must not restart the session.
  task automatic test_single_word();
    wr_addr_q.delete(); wr_data_q.delete();
    pulse_start();
    vectors++;
    if ({in_ready, program_mode, core_rst_n, done} !== 4'b1100) begin
      miscompares++;
      $display("FAIL load_ctrl: rdy,prog,crst_n,done=%b required 1100",
               {in_ready, program_mode, core_rst_n, done});
    end
    send_word(32'd1, 1'b0);
    pulse_start();
    send_word(32'h0000_0537, 1'b0);
    send_chk(32'h0000_0537, 1'b0);
    wait_end();
    vectors++;
    if (wr_addr_q.size() != 1) begin
      miscompares++;
      $display("FAIL single_count: writes=%0d required 1", wr_addr_q.size());
    end else begin
      vectors++;
      if (wr_addr_q[0] !== 4'd0 || wr_data_q[0] !== 32'h0000_0537) begin
        miscompares++;
        $display("FAIL single_write: addr=%h data=%h required 0/00000537",
                 wr_addr_q[0], wr_data_q[0]);
      end
    end
    vectors++;
    if ({done, core_rst_n, program_mode, error, imem_w_en} !== 5'b11000) begin
      miscompares++;
      $display("FAIL single_done: done,crst_n,prog,err,wen=%b required 11000",
               {done, core_rst_n, program_mode, error, imem_w_en});
    end
    vectors++;
    if (imem_data !== 32'h0000_0537 || words_loaded !== 5'd1) begin
      miscompares++;
      $display("FAIL single_hold: data=%h words=%0d required 00000537/1", imem_data, words_loaded);
    end
  endtask

  task automatic test_gapped(input logic [31:0] chk, input bit expect_ok);
    wr_addr_q.delete(); wr_data_q.delete();
    pulse_start();
    send_word(32'd2, 1'b1);
    send_word(32'h0000_0537, 1'b1);
    send_word(32'h0010_0093, 1'b1);
    send_chk(chk, 1'b1);
    wait_end();
    vectors++;
    if (wr_addr_q.size() != 2) begin
      miscompares++;
      $display("FAIL gapped_count: writes=%0d required 2", wr_addr_q.size());
    end else begin
      vectors++;
      if (wr_addr_q[0] !== 4'd0 || wr_data_q[0] !== 32'h0000_0537 ||
          wr_addr_q[1] !== 4'd1 || wr_data_q[1] !== 32'h0010_0093) begin
        miscompares++;
        $display("FAIL gapped_writes: %h@%h %h@%h required 00000537@0 00100093@1",
                 wr_data_q[0], wr_addr_q[0], wr_data_q[1], wr_addr_q[1]);
      end
    end
    vectors++;
    if (words_loaded !== 5'd2) begin
      miscompares++;
      $display("FAIL gapped_words: words_loaded=%0d required 2", words_loaded);
    end
    vectors++;
    if ({done, error, core_rst_n} !== (expect_ok ? 3'b101 : 3'b010)) begin
      miscompares++;
      $display("FAIL gapped_end: done,err,crst_n=%b required %b",
               {done, error, core_rst_n}, expect_ok ? 3'b101 : 3'b010);
    end
  endtask

  task automatic test_too_long();
    wr_addr_q.delete(); wr_data_q.delete();
    pulse_start();
    send_word(MW + 1, 1'b0);
    wait_end();
    repeat (3) @(negedge clk);
    vectors++;
    if ({error, done, core_rst_n, program_mode, in_ready} !== 5'b10000) begin
      miscompares++;
      $display("FAIL too_long_state: err,done,crst_n,prog,rdy=%b required 10000",
               {error, done, core_rst_n, program_mode, in_ready});
    end
    vectors++;
    if (wr_addr_q.size() != 0 || words_loaded !== '0) begin
      miscompares++;
      $display("FAIL too_long_writes: writes=%0d words=%0d required 0/0",
               wr_addr_q.size(), words_loaded);
    end
  endtask

  task automatic test_max_len();
    logic [31:0] w, x;
    x = 32'h0;
    wr_addr_q.delete(); wr_data_q.delete();
    pulse_start();
    send_word(MW, 1'b0);
    for (int i = 0; i < MW; i++) begin
      w = 32'h1357_0000 + 32'(i) * 32'h0001_0203;
      x = x ^ w;
      send_word(w, 1'b0);
    end
    send_chk(x, 1'b0);
    wait_end();
    vectors++;
    if (wr_addr_q.size() != MW) begin
      miscompares++;
      $display("FAIL max_count: writes=%0d required %0d", wr_addr_q.size(), MW);
    end else begin
      for (int i = 0; i < MW; i++) begin
        w = 32'h1357_0000 + 32'(i) * 32'h0001_0203;
        vectors++;
        if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== w) begin
          miscompares++;
          $display("FAIL max_write%0d: %h@%h required %h@%h", i, wr_data_q[i], wr_addr_q[i],
                   w, AW'(i));
        end
      end
    end
    vectors++;
    if (done !== 1'b1 || words_loaded !== 5'(MW)) begin
      miscompares++;
      $display("FAIL max_end: done=%b words=%0d required 1/%0d", done, words_loaded, MW);
    end
  endtask

  task automatic test_zero();
    wr_addr_q.delete(); wr_data_q.delete();
    pulse_start();
    send_word(32'd0, 1'b0);
    send_chk(32'h0, 1'b0);
    wait_end();
    vectors++;
    if (done !== 1'b1 || error !== 1'b0 || wr_addr_q.size() != 0 || words_loaded !== '0) begin
      miscompares++;
      $display("FAIL zero_len: done=%b err=%b writes=%0d words=%0d required 1/0/0/0",
               done, error, wr_addr_q.size(), words_loaded);
    end
  endtask

  task automatic test_reset_mid();
    pulse_start();
    send_word(32'd1, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    vectors++;
    if ({in_ready, program_mode, imem_w_en} !== 3'b000 || words_loaded !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: rdy,prog,wen=%b words=%0d required 000/0",
               {in_ready, program_mode, imem_w_en}, words_loaded);
    end
    wr_addr_q.delete(); wr_data_q.delete();
    pulse_start();
    send_word(32'd1, 1'b0);
    send_word(32'hCAFE_F00D, 1'b0);
    send_chk(32'hCAFE_F00D, 1'b0);
    wait_end();
    vectors++;
    if (wr_addr_q.size() != 1) begin
      miscompares++;
      $display("FAIL mid_count: writes=%0d required 1", wr_addr_q.size());
    end else begin
      vectors++;
      if (wr_addr_q[0] !== 4'd0 || wr_data_q[0] !== 32'hCAFE_F00D) begin
        miscompares++;
        $display("FAIL mid_write: %h@%h required cafef00d@0", wr_data_q[0], wr_addr_q[0]);
      end
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_done: done=%b required 1", done);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_gapped(32'h0010_05A4, 1'b1);
`ifdef RV32_LOADER_CHKSUM_EN
    test_gapped(32'h0010_05A5, 1'b0);
`endif
    test_too_long();
    test_max_len();
    test_zero();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rv32_prog_loader.md
RV32_PROG_LOADER -- requirements
Module: rv32_prog_loader

Interface
REQ-001 Parameter IMEM_ADDR_W, default 10, SHALL set the instruction-memory word-address width (depth 2**IMEM_ADDR_W words).
REQ-002 Parameter MAX_WORDS, default 2**IMEM_ADDR_W, SHALL set the largest accepted program length in words.
REQ-003 rv32_io_clk  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-004 rv32_io_rst  in  1  SHALL be a synchronous, active-high reset.
REQ-005 start  in  1  SHALL be a single-cycle pulse that begins a load session.
REQ-006 in_valid  in  1  SHALL flag a valid byte on in_data.
REQ-007 in_data  in  8  SHALL carry the byte stream (header, words, optional checksum).
REQ-008 in_ready  out  1  SHALL indicate the loader accepts a byte this cycle.
REQ-009 imem_w_en  out  1  SHALL be the write strobe to core instruction memory.
REQ-010 imem_addr  out  IMEM_ADDR_W  SHALL be the instruction-memory word address.
REQ-011 imem_data  out  32  SHALL be the instruction word to write.
REQ-012 core_rst_n  out  1  SHALL hold the core in reset (low) while loading.
REQ-013 program  out  1  SHALL drive the core program-mode input, high while loading.
REQ-014 done  out  1  SHALL be high in DONE.
REQ-015 error  out  1  SHALL be high in ERR.
REQ-016 words_loaded  out  IMEM_ADDR_W+1  SHALL count words written this session.

Function
REQ-017 FSM states SHALL be IDLE, HDR, DATA, CHK, WAIT_WR, DONE and ERR.
REQ-018 A byte SHALL transfer only on a cycle with in_valid && in_ready; in_ready SHALL be high only in HDR, DATA and CHK.
REQ-019 start in IDLE, DONE or ERR SHALL go to HDR, clear words_loaded, done and error, and drive core_rst_n=0, program=1; start in any other state SHALL be ignored.
REQ-020 HDR SHALL take 4 bytes, little-endian, as 32-bit word count N.
REQ-021 N==0 SHALL go directly to DONE (or to CHK when checksum is enabled); N>MAX_WORDS SHALL go to ERR with no memory write.
REQ-022 DATA SHALL assemble 4 bytes little-endian per word; the 4th byte's cycle SHALL register imem_data and imem_addr=words_loaded[IMEM_ADDR_W-1:0] and assert imem_w_en for exactly the next cycle (WAIT_WR), in_ready low during that cycle.
REQ-023 words_loaded SHALL increment in the write cycle; after N writes the FSM SHALL go to DONE (or CHK).
REQ-024 In DONE: core_rst_n=1, program=0, done=1, imem_w_en=0; in ERR: core_rst_n=0, program=0, error=1.
REQ-025 Gaps in in_valid SHALL stall assembly without losing partial bytes.
REQ-026 imem_addr and imem_data SHALL hold their last values when imem_w_en is low.

Reset
REQ-027 rv32_io_rst SHALL force IDLE, discard partial words and checksum, and drive in_ready=0, imem_w_en=0, imem_addr=0, imem_data=0, core_rst_n=0, program=0, done=0, error=0, words_loaded=0.
REQ-028 Reset mid-session SHALL take priority over start and byte transfers in the same cycle.

Configuration
REQ-029 With RV32_LOADER_CHKSUM_EN defined, the loader SHALL XOR all N words, accept a 4-byte little-endian checksum in CHK, and go to DONE on match or ERR on mismatch.
REQ-030 Without RV32_LOADER_CHKSUM_EN, CHK SHALL be unreachable and no checksum byte SHALL be consumed.

Structure
REQ-031 The state enum, rv32_imem_addr_t and rv32_instr_t SHALL live in the shared rv32 package.
REQ-032 One sub-module, rv32_byte_packer (4-byte little-endian assembler with count and flush), SHALL be used for header, data and checksum.

Verification
REQ-033 start; bytes 01 00 00 00, 37 05 00 00 -> one imem_w_en, addr 0, data 0x00000537, then done=1, core_rst_n=1.
REQ-034 N=2, words 0x00000537, 0x00100093, in_valid toggling every cycle -> writes at addr 0 then 1, words_loaded=2.
REQ-035 Header N=MAX_WORDS+1 -> error=1, no imem_w_en, core_rst_n=0.
REQ-036 rv32_io_rst after 2 data bytes, then a fresh session with N=1 -> only the new word is written, at addr 0.
REQ-037 RV32_LOADER_CHKSUM_EN, N=2 as REQ-034, checksum 0x001005A4 -> done=1; checksum 0x001005A5 -> error=1.
